// File: rtl/sram1p_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters,
// with a registered command stage and a tagged read response (latency 2).
// Optional build macro: SRAM1P_ARB_WRITE_PRIO_EN (writers win over readers).
module sram1p_rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_wdata,
  output logic                           sram_write_enable,
  output logic                           sram_read_enable,
  output logic [ADDR_SIZE-1:0]           sram_address,
  output logic [WORD_SIZE-1:0]           sram_write_data,
  input  logic [WORD_SIZE-1:0]           sram_read_data,
  output logic                           rsp_valid,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [WORD_SIZE-1:0]           rsp_data
);

  localparam int unsigned SUM_W = ID_WIDTH + 1;

  logic [ID_WIDTH-1:0]  r_ptr;
  logic                 r_sram_we;
  logic                 r_sram_re;
  logic [ADDR_SIZE-1:0] r_sram_addr;
  logic [WORD_SIZE-1:0] r_sram_wdata;
  logic [ID_WIDTH-1:0]  r_issue_id;
  logic                 r_rsp_valid;
  logic [ID_WIDTH-1:0]  r_rsp_id;

  logic [NUM_REQ-1:0]   w_cand;
  logic                 w_found;
  logic [ID_WIDTH-1:0]  w_gnt_id;
  logic [ID_WIDTH-1:0]  w_idx;
  logic                 w_hs;
  logic [ID_WIDTH-1:0]  w_ptr_nxt;
  logic                 w_gnt_we;
  logic [ADDR_SIZE-1:0] w_gnt_addr;
  logic [WORD_SIZE-1:0] w_gnt_wdata;

  // (base + off) mod NUM_REQ, both operands already below NUM_REQ
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                    input logic [SUM_W-1:0]    off);
    logic [SUM_W-1:0] s;
    s = {1'b0, base} + off;
    if (s >= SUM_W'(NUM_REQ)) s = s - SUM_W'(NUM_REQ);
    return s[ID_WIDTH-1:0];
  endfunction

`ifdef SRAM1P_ARB_WRITE_PRIO_EN
  logic [NUM_REQ-1:0] w_wr_valid;
  assign w_wr_valid = req_valid & req_we;
  assign w_cand     = (|w_wr_valid) ? w_wr_valid : req_valid;
`else
  assign w_cand     = req_valid;
`endif

  // Circular scan from the pointer; first candidate wins
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = wrap_add(r_ptr, SUM_W'(i));
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  assign w_hs = w_found & ~rst;

  always_comb begin
    req_ready = '0;
    if (w_hs) req_ready[w_gnt_id] = 1'b1;
  end

  // Select the granted requester's command fields
  always_comb begin
    w_gnt_we    = 1'b0;
    w_gnt_addr  = '0;
    w_gnt_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == w_gnt_id) begin
        w_gnt_we    = req_we[i];
        w_gnt_addr  = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
        w_gnt_wdata = req_wdata[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Command stage; enables are one-hot or idle, address/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_we    <= 1'b0;
      r_sram_re    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_issue_id   <= '0;
    end else if (w_hs) begin
      r_sram_we    <= w_gnt_we;
      r_sram_re    <= ~w_gnt_we;
      r_sram_addr  <= w_gnt_addr;
      r_sram_wdata <= w_gnt_wdata;
      r_issue_id   <= w_gnt_id;
    end else begin
      r_sram_we    <= 1'b0;
      r_sram_re    <= 1'b0;
    end
  end

  // Response tag follows the SRAM's registered read by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_rsp_valid <= r_sram_re;
      r_rsp_id    <= r_issue_id;
    end
  end

  assign sram_write_enable = r_sram_we;
  assign sram_read_enable  = r_sram_re;
  assign sram_address      = r_sram_addr;
  assign sram_write_data   = r_sram_wdata;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_id            = r_rsp_id;
  assign rsp_data          = sram_read_data;

endmodule
